// File: rtl/inst_fetch_queue_pkg.sv
// Shared types for the IF->ID instruction queue; the entry layout is also
// consumed by ID decode.
package inst_fetch_queue_pkg;
    localparam int          XLEN        = 32;
    localparam int          EXCP_CODE_W = 7;
    localparam logic [31:0] INST_NOP    = 32'h0340_0000;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [XLEN-1:0]        inst;
        logic                   excp;
        logic [EXCP_CODE_W-1:0] exception;
        logic                   taken;
        logic [XLEN-1:0]        target;
    } ifq_entry_t;
endpackage

// File: rtl/inst_fetch_queue_pair_select.sv
// Combinational head-pair selection: decides single/dual issue and builds the
// fifo_id_* fields from the two oldest entries.
module ifq_pair_select
    import inst_fetch_queue_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic [CNT_W-1:0]       count_i,
    input  ifq_entry_t             head0_i,
    input  ifq_entry_t             head1_i,
    output logic                   readygo_o,
    output logic                   pair_o,
    output logic [XLEN-1:0]        pc0_o,
    output logic [XLEN-1:0]        pc1_o,
    output logic [XLEN-1:0]        inst0_o,
    output logic [XLEN-1:0]        inst1_o,
    output logic [XLEN-1:0]        pc_next_o,
    output logic                   pc_taken_o,
    output logic [XLEN-1:0]        badv_o,
    output logic [1:0]             excp_flag_o,
    output logic [EXCP_CODE_W-1:0] exception_o,
    output logic [1:0]             branch_flag_o
);
    always_comb begin
        readygo_o     = (count_i != '0);
        // Excepting or taken head ends the group: nothing after it is on-path.
        pair_o        = (count_i > CNT_W'(1)) && !head0_i.excp && !head0_i.taken;
        pc0_o         = '0;
        pc1_o         = '0;
        inst0_o       = INST_NOP;
        inst1_o       = INST_NOP;
        pc_next_o     = '0;
        pc_taken_o    = 1'b0;
        badv_o        = '0;
        excp_flag_o   = '0;
        exception_o   = '0;
        branch_flag_o = '0;
        if (readygo_o) begin
            pc0_o          = head0_i.pc;
            inst0_o        = head0_i.inst;
            excp_flag_o[0] = head0_i.excp;
            branch_flag_o[0] = head0_i.taken;
            pc_taken_o     = head0_i.taken;
            pc_next_o      = head0_i.taken ? head0_i.target : head0_i.pc + 32'd4;
            if (pair_o) begin
                pc1_o            = head1_i.pc;
                inst1_o          = head1_i.inst;
                excp_flag_o[1]   = head1_i.excp;
                branch_flag_o[1] = head1_i.taken;
                pc_taken_o       = head1_i.taken;
                pc_next_o        = head1_i.taken ? head1_i.target : head1_i.pc + 32'd4;
            end
            if (excp_flag_o[0]) begin
                exception_o = head0_i.exception;
                badv_o      = head0_i.pc;
            end else if (excp_flag_o[1]) begin
                exception_o = head1_i.exception;
                badv_o      = head1_i.pc;
            end
        end
    end
endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-lane IF->ID instruction buffer: circular flop storage with wrap-bit
// pointers, two pushes and up to two pops per cycle.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   flush,
    input  logic [1:0]             if_valid,
    output logic                   if_allowin,
    input  logic [31:0]            if_pc0,
    input  logic [31:0]            if_pc1,
    input  logic [31:0]            if_inst0,
    input  logic [31:0]            if_inst1,
    input  logic                   if_excp0,
    input  logic                   if_excp1,
    input  logic [EXCP_CODE_W-1:0] if_exception0,
    input  logic [EXCP_CODE_W-1:0] if_exception1,
    input  logic                   if_taken0,
    input  logic                   if_taken1,
    input  logic [31:0]            if_target0,
    input  logic [31:0]            if_target1,
    output logic                   fifo_readygo,
    input  logic                   id_allowin,
    output logic [31:0]            fifo_id_pc0,
    output logic [31:0]            fifo_id_pc1,
    output logic [31:0]            fifo_id_inst0,
    output logic [31:0]            fifo_id_inst1,
    output logic [31:0]            fifo_id_pc_next,
    output logic                   fifo_id_pc_taken,
    output logic [31:0]            fifo_id_badv,
    output logic [1:0]             fifo_id_excp_flag,
    output logic [EXCP_CODE_W-1:0] fifo_id_exception,
    output logic [1:0]             fifo_id_branch_flag
);
    ifq_entry_t     mem_q [DEPTH];
    logic [PTR_W:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [PTR_W:0] n_push, n_pop;
    logic [PTR_W-1:0] wr0, wr1, rd0, rd1;
    logic           push_ok, pair;
    ifq_entry_t     lane0, lane1;

    assign lane0 = '{pc: if_pc0, inst: if_inst0, excp: if_excp0, exception: if_exception0,
                     taken: if_taken0, target: if_target0};
    assign lane1 = '{pc: if_pc1, inst: if_inst1, excp: if_excp1, exception: if_exception1,
                     taken: if_taken1, target: if_target1};

    // Space check uses the registered count only; a same-cycle pop is not credited.
    assign if_allowin = ((PTR_W+1)'(DEPTH) - count_q) >= (PTR_W+1)'(2);
    assign push_ok    = if_allowin && if_valid[0];
    assign n_push     = push_ok ? (if_valid[1] ? (PTR_W+1)'(2) : (PTR_W+1)'(1)) : '0;
    assign n_pop      = (fifo_readygo && id_allowin) ? (pair ? (PTR_W+1)'(2) : (PTR_W+1)'(1)) : '0;

    assign wr0 = tail_q[PTR_W-1:0];
    assign wr1 = PTR_W'(tail_q[PTR_W-1:0] + 1'b1);
    assign rd0 = head_q[PTR_W-1:0];
    assign rd1 = PTR_W'(head_q[PTR_W-1:0] + 1'b1);

    assign head_d  = head_q + n_pop;
    assign tail_d  = tail_q + n_push;
    assign count_d = count_q + n_push - n_pop;

    always_ff @(posedge aclk) begin
        if (!aresetn || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && !flush && push_ok) begin
            mem_q[wr0] <= lane0;
            if (if_valid[1]) mem_q[wr1] <= lane1;
        end
    end

    ifq_pair_select #(.CNT_W(PTR_W+1)) u_sel (
        .count_i       (count_q),
        .head0_i       (mem_q[rd0]),
        .head1_i       (mem_q[rd1]),
        .readygo_o     (fifo_readygo),
        .pair_o        (pair),
        .pc0_o         (fifo_id_pc0),
        .pc1_o         (fifo_id_pc1),
        .inst0_o       (fifo_id_inst0),
        .inst1_o       (fifo_id_inst1),
        .pc_next_o     (fifo_id_pc_next),
        .pc_taken_o    (fifo_id_pc_taken),
        .badv_o        (fifo_id_badv),
        .excp_flag_o   (fifo_id_excp_flag),
        .exception_o   (fifo_id_exception),
        .branch_flag_o (fifo_id_branch_flag)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: handshake, pairing rules, exceptions,
// fill/drain across pointer wrap, flush and mid-run reset.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn, flush, id_allowin;
    logic [1:0]  if_valid;
    logic        if_allowin, fifo_readygo;
    logic [31:0] if_pc0, if_pc1, if_inst0, if_inst1, if_target0, if_target1;
    logic        if_excp0, if_excp1, if_taken0, if_taken1;
    logic [6:0]  if_exception0, if_exception1;
    logic [31:0] fifo_id_pc0, fifo_id_pc1, fifo_id_inst0, fifo_id_inst1;
    logic [31:0] fifo_id_pc_next, fifo_id_badv;
    logic        fifo_id_pc_taken;
    logic [1:0]  fifo_id_excp_flag, fifo_id_branch_flag;
    logic [6:0]  fifo_id_exception;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    inst_fetch_queue dut (
        .aclk(aclk), .aresetn(aresetn), .flush(flush), .if_valid(if_valid),
        .if_allowin(if_allowin), .if_pc0(if_pc0), .if_pc1(if_pc1),
        .if_inst0(if_inst0), .if_inst1(if_inst1), .if_excp0(if_excp0), .if_excp1(if_excp1),
        .if_exception0(if_exception0), .if_exception1(if_exception1),
        .if_taken0(if_taken0), .if_taken1(if_taken1),
        .if_target0(if_target0), .if_target1(if_target1),
        .fifo_readygo(fifo_readygo), .id_allowin(id_allowin),
        .fifo_id_pc0(fifo_id_pc0), .fifo_id_pc1(fifo_id_pc1),
        .fifo_id_inst0(fifo_id_inst0), .fifo_id_inst1(fifo_id_inst1),
        .fifo_id_pc_next(fifo_id_pc_next), .fifo_id_pc_taken(fifo_id_pc_taken),
        .fifo_id_badv(fifo_id_badv), .fifo_id_excp_flag(fifo_id_excp_flag),
        .fifo_id_exception(fifo_id_exception), .fifo_id_branch_flag(fifo_id_branch_flag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set0(input logic [31:0] pc, input logic tk = 1'b0, input logic [31:0] tg = '0,
                        input logic ex = 1'b0, input logic [6:0] code = '0);
        if_pc0 = pc; if_inst0 = pc ^ 32'hA5A5_0000; if_taken0 = tk; if_target0 = tg;
        if_excp0 = ex; if_exception0 = code;
    endtask

    task automatic set1(input logic [31:0] pc, input logic tk = 1'b0, input logic [31:0] tg = '0,
                        input logic ex = 1'b0, input logic [6:0] code = '0);
        if_pc1 = pc; if_inst1 = pc ^ 32'hA5A5_0000; if_taken1 = tk; if_target1 = tg;
        if_excp1 = ex; if_exception1 = code;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".readygo"}, 32'(fifo_readygo), 32'd0);
        chk({tag, ".inst0"}, fifo_id_inst0, INST_NOP);
        chk({tag, ".inst1"}, fifo_id_inst1, INST_NOP);
        chk({tag, ".pc0"}, fifo_id_pc0, 32'd0);
        chk({tag, ".pc_next"}, fifo_id_pc_next, 32'd0);
    endtask

    localparam logic [31:0] BASE = 32'h1c00_1000;

    initial begin
        aresetn = 1'b0; flush = 1'b0; id_allowin = 1'b0; if_valid = 2'b00;
        set0('0); set1('0);
        tick(); tick();
        chk_empty("reset");
        chk("reset.allowin", 32'(if_allowin), 32'd1);
        chk("reset.excp", 32'(fifo_id_excp_flag), 32'd0);
        chk("reset.badv", fifo_id_badv, 32'd0);

        // Plain pair, then pop both.
        aresetn = 1'b1;
        set0(32'h1c00_0000); set1(32'h1c00_0004); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("pair.readygo", 32'(fifo_readygo), 32'd1);
        chk("pair.pc0", fifo_id_pc0, 32'h1c00_0000);
        chk("pair.pc1", fifo_id_pc1, 32'h1c00_0004);
        chk("pair.inst1", fifo_id_inst1, 32'hb9a5_0004);
        chk("pair.pc_next", fifo_id_pc_next, 32'h1c00_0008);
        chk("pair.taken", 32'(fifo_id_pc_taken), 32'd0);
        id_allowin = 1'b1;
        tick(); id_allowin = 1'b0;
        chk("pair.drained", 32'(fifo_readygo), 32'd0);

        // Single lane push.
        set0(32'h1c00_0010); if_valid = 2'b01;
        tick(); if_valid = 2'b00;
        chk("single.pc0", fifo_id_pc0, 32'h1c00_0010);
        chk("single.inst1", fifo_id_inst1, INST_NOP);
        chk("single.pc1", fifo_id_pc1, 32'd0);
        chk("single.pc_next", fifo_id_pc_next, 32'h1c00_0014);
        id_allowin = 1'b1;
        tick(); id_allowin = 1'b0;
        chk("single.drained", 32'(fifo_readygo), 32'd0);

        // Taken head blocks pairing.
        set0(32'h1c00_0040, 1'b1, 32'h1c00_0100); set1(32'h1c00_0100); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("taken.pc_taken", 32'(fifo_id_pc_taken), 32'd1);
        chk("taken.pc_next", fifo_id_pc_next, 32'h1c00_0100);
        chk("taken.bflag", 32'(fifo_id_branch_flag), 32'd1);
        chk("taken.inst1", fifo_id_inst1, INST_NOP);
        id_allowin = 1'b1;
        tick();
        chk("taken.second.pc0", fifo_id_pc0, 32'h1c00_0100);
        chk("taken.second.pc_next", fifo_id_pc_next, 32'h1c00_0104);
        chk("taken.second.bflag", 32'(fifo_id_branch_flag), 32'd0);
        tick(); id_allowin = 1'b0;
        chk("taken.drained", 32'(fifo_readygo), 32'd0);

        // Excepting head: single issue, code and badv from lane0.
        set0(32'h1c00_0020, 1'b0, '0, 1'b1, 7'h08); set1(32'h1c00_0024); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("excp0.flag", 32'(fifo_id_excp_flag), 32'd1);
        chk("excp0.code", 32'(fifo_id_exception), 32'h08);
        chk("excp0.badv", fifo_id_badv, 32'h1c00_0020);
        chk("excp0.inst1", fifo_id_inst1, INST_NOP);
        id_allowin = 1'b1;
        tick(); tick(); id_allowin = 1'b0;
        chk("excp0.drained", 32'(fifo_readygo), 32'd0);

        // Exception on lane1 still pairs; code comes from lane1.
        set0(32'h1c00_0030); set1(32'h1c00_0034, 1'b0, '0, 1'b1, 7'h0a); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("excp1.flag", 32'(fifo_id_excp_flag), 32'd2);
        chk("excp1.code", 32'(fifo_id_exception), 32'h0a);
        chk("excp1.badv", fifo_id_badv, 32'h1c00_0034);
        id_allowin = 1'b1;
        tick(); id_allowin = 1'b0;
        chk("excp1.drained", 32'(fifo_readygo), 32'd0);

        // Fill to 15 without popping; pointers wrap past the end of storage.
        for (int p = 0; p < 7; p++) begin
            chk("fill.allowin", 32'(if_allowin), 32'd1);
            set0(BASE + 32'(8 * p)); set1(BASE + 32'(8 * p + 4)); if_valid = 2'b11;
            tick();
        end
        chk("fill.allowin14", 32'(if_allowin), 32'd1);
        set0(BASE + 32'd56); if_valid = 2'b01;
        tick();
        chk("fill.allowin15", 32'(if_allowin), 32'd0);
        set0(32'hdead_0000); set1(32'hdead_0004); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("fill.dropped.allowin", 32'(if_allowin), 32'd0);
        id_allowin = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain.pc0", fifo_id_pc0, BASE + 32'(8 * i));
            chk("drain.inst0", fifo_id_inst0, (BASE + 32'(8 * i)) ^ 32'hA5A5_0000);
            chk("drain.pc1", fifo_id_pc1, (i < 7) ? BASE + 32'(8 * i + 4) : 32'd0);
            tick();
        end
        id_allowin = 1'b0;
        chk_empty("drain.end");

        // Flush with simultaneous push and pop at count 6.
        for (int p = 0; p < 3; p++) begin
            set0(32'h1c00_2000 + 32'(8 * p)); set1(32'h1c00_2004 + 32'(8 * p)); if_valid = 2'b11;
            tick();
        end
        flush = 1'b1; id_allowin = 1'b1;
        tick();
        flush = 1'b0; id_allowin = 1'b0; if_valid = 2'b00;
        chk_empty("flush");
        chk("flush.allowin", 32'(if_allowin), 32'd1);
        tick();
        chk("flush.stays_empty", 32'(fifo_readygo), 32'd0);

        // Reset in mid-operation.
        set0(32'h1c00_3000); set1(32'h1c00_3004); if_valid = 2'b11;
        tick(); if_valid = 2'b00;
        chk("midrst.pre", 32'(fifo_readygo), 32'd1);
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk_empty("midrst");
        chk("midrst.allowin", 32'(if_allowin), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Dual-lane instruction buffer between IF and ID; it is the producer side of the fifo_id_* bundle that ID consumes.
- Accepts up to 2 fetched instructions per cycle from IF.
- Presents a pair (or a single instruction) per cycle to ID under a readygo/allowin handshake.
- Decouples fetch stalls from decode stalls and absorbs pipeline flushes.

Parameters:
- DEPTH, 16, number of single-instruction entries; power of 2, at least 4.
- PTR_W, log2(DEPTH), index width; pointers carry one extra wrap bit.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- flush  in  1  discard all contents (branch mispredict or exception)
- if_valid  in  2  per-lane push valid; 2'b10 is illegal
- if_allowin  out  1  queue can take a 2-lane push this cycle
- if_pc0, if_pc1  in  32  lane PCs
- if_inst0, if_inst1  in  32  lane instructions
- if_excp0, if_excp1  in  1  lane carries a fetch exception
- if_exception0, if_exception1  in  7  exception code
- if_taken0, if_taken1  in  1  predictor says taken
- if_target0, if_target1  in  32  predicted target
- fifo_readygo  out  1  at least one instruction presented
- id_allowin  in  1  ID accepts this cycle
- fifo_id_pc0, fifo_id_pc1  out  32
- fifo_id_inst0, fifo_id_inst1  out  32
- fifo_id_pc_next  out  32  fetch-next PC after the presented group
- fifo_id_pc_taken  out  1
- fifo_id_badv  out  32  PC of the excepting lane
- fifo_id_excp_flag  out  2  per-lane exception
- fifo_id_exception  out  7  code of the lowest excepting lane
- fifo_id_branch_flag  out  2  per-lane predicted-taken

Behaviour:
- Storage: circular buffer of DEPTH flop entries {pc, inst, excp, exception, taken, target}. Head/tail pointers are PTR_W+1 bits; count is PTR_W+1 bits.
- Push:
  - if_allowin = (DEPTH - count) >= 2, computed from the registered count only; it does not credit a same-cycle pop.
  - When if_allowin and if_valid[0]: lane0 written at tail; lane1 at tail+1 if if_valid[1]; tail advances by popcount(if_valid).
  - Push while if_allowin=0 is dropped. IF must hold.
- Presentation (combinational from head entries):
  - fifo_readygo = (count != 0).
  - Lane1 is paired only if count >= 2, head entry has excp=0, and head entry has taken=0.
- Output fields:
  - Unpaired lane1: fifo_id_inst1 = INST_NOP (32'h03400000), pc1 = 0, excp_flag[1] = 0, branch_flag[1] = 0.
  - fifo_id_pc_next: target of the last presented lane if it is taken, else its pc + 4. fifo_id_pc_taken = that lane's taken.
  - fifo_id_exception / fifo_id_badv come from lane0 if excp_flag[0], else lane1 if excp_flag[1], else 0.
- Pop:
  - Pop occurs when fifo_readygo & id_allowin; head advances by 1 or 2 (number presented).
  - count_next = count + pushed - popped. Simultaneous push and pop in one cycle is legal.
- Latency: an entry pushed at edge N is visible on outputs after edge N. There is no write-to-read bypass.
- Wrap-around: pointer index arithmetic is modulo DEPTH; the extra wrap bit distinguishes full from empty.
- Full: count == DEPTH gives if_allowin = 0; the queue still presents and pops.
- Empty: fifo_readygo = 0 and all outputs at reset values; id_allowin is ignored.
- flush: synchronous and highest priority after reset. head = tail = count = 0 next cycle; same-cycle push and pop are discarded.
- Reset, including mid-operation: head = tail = count = 0.
  - Outputs: fifo_readygo = 0, inst0 = inst1 = INST_NOP, all other outputs 0.
  - Entry contents are don't-care.

Decomposition:
- Shared package holds:
  - INST_NOP
  - EXCP_CODE_W = 7
  - the entry field widths / packed entry layout, shared with ID decode.
- Optional single sub-module ifq_pair_select: combinational head-pair selection plus pc_next/exception muxing. Storage and pointers stay in the top module.

Test Plan:
- Reset then push {0x1c000000, 0x1c000004} with no taken/excp → next cycle fifo_readygo = 1, pair presented, pc_next = 0x1c000008; id_allowin = 1 → count 0.
- Push a single lane at 0x1c000010 → lane1 = NOP, pc1 = 0, pc_next = 0x1c000014.
- Head taken with target 0x1c000100, second entry present → only lane0 presented, pc_taken = 1, pc_next = 0x1c000100; the following cycle presents the second entry.
- Head excp = 1, code 0x08, pc 0x1c000020 → excp_flag = 2'b01, exception = 0x08, badv = 0x1c000020, single issue.
- Fill to DEPTH with id_allowin = 0 → if_allowin drops at count = 15. Further pushes ignored. Drain and check FIFO order across pointer wrap.
- flush asserted together with a push and a pop at count 6 → next cycle count = 0, fifo_readygo = 0, if_allowin = 1.
